// File: rtl/seg7_uart_display.sv
// Four-digit multiplexed 7-segment display fed by received UART bytes.
// Ports: clk_30MHz, reset_n, rx_valid/rx_data in; seg, dp, an, bad_char, err_cnt out.
module seg7_uart_display #(
  parameter int unsigned REFRESH_DIV = 30000
) (
  input  logic       clk_30MHz,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       bad_char,
  output logic [7:0] err_cnt
);

  localparam logic [15:0] LAST = 16'(REFRESH_DIV - 1);

  logic [3:0]  nib [4];
  logic [3:0]  vld;
  logic [3:0]  dpb;
  logic [15:0] cnt;
  logic [1:0]  scan;

  logic       is_num;
  logic       is_uc;
  logic       is_lc;
  logic       is_hex;
  logic       is_dot;
  logic       is_clr;
  logic       is_eol;
  logic       is_bad;
  logic [3:0] val;

  always_comb begin
    is_num = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_uc  = (rx_data >= 8'h41) && (rx_data <= 8'h46);
    is_lc  = (rx_data >= 8'h61) && (rx_data <= 8'h66);
    is_hex = is_num | is_uc | is_lc;
    is_dot = (rx_data == 8'h2E);
    is_clr = (rx_data == 8'h23);
    is_eol = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    is_bad = ~(is_hex | is_dot | is_clr | is_eol);
    // Letters carry value-9 in their low nibble ('A' = 0x41 -> 10).
    val = is_num ? rx_data[3:0] : rx_data[3:0] + 4'd9;
  end

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk_30MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) nib[i] <= 4'h0;
      vld <= 4'h0;
      dpb <= 4'h0;
    end else if (rx_valid) begin
      unique case (1'b1)
        is_hex: begin
          nib[3] <= nib[2];
          nib[2] <= nib[1];
          nib[1] <= nib[0];
          nib[0] <= val;
          vld    <= {vld[2:0], 1'b1};
          dpb    <= {dpb[2:0], 1'b0};
        end
        is_dot: begin
          if (vld[0]) dpb[0] <= 1'b1;
        end
        is_clr: begin
          vld <= 4'h0;
          dpb <= 4'h0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_30MHz or negedge reset_n) begin
    if (!reset_n) begin
      bad_char <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      bad_char <= rx_valid & is_bad;
      if (rx_valid && is_bad && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_30MHz or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 16'd0;
      scan <= 2'd0;
    end else if (cnt == LAST) begin
      cnt  <= 16'd0;
      scan <= scan + 2'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Outputs come from the scan index and buffer as held before this
  // edge, so an and seg/dp always switch together.
  always_ff @(posedge clk_30MHz or negedge reset_n) begin
    if (!reset_n) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'b1110;
    end else begin
      seg <= vld[scan] ? font(nib[scan]) : 7'h7F;
      dp  <= ~(vld[scan] & dpb[scan]);
      an  <= ~(4'b0001 << scan);
    end
  end

endmodule

// File: tb/tb_seg7_uart_display.sv
// Directed bench for seg7_uart_display with REFRESH_DIV=4.
// Hand-computed expectations checked by immediate assertions.
module tb_seg7_uart_display;

  logic       clk_30MHz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       rx_valid  = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       bad_char;
  logic [7:0] err_cnt;

  int vectors = 0;
  int miscompares = 0;

  seg7_uart_display #(.REFRESH_DIV(4)) dut (
    .clk_30MHz(clk_30MHz),
    .reset_n  (reset_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .bad_char (bad_char),
    .err_cnt  (err_cnt)
  );

  always #5 clk_30MHz = ~clk_30MHz;

  task automatic tick();
    @(posedge clk_30MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Wait (bounded) for the scan to reach digit idx, then check it.
  task automatic digit(input string tag, input int idx,
                       input logic [6:0] s, input logic d);
    logic [3:0] ea;
    ea = ~(4'b0001 << idx);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (an === ea) break;
      tick();
    end
    chk({tag, " an"}, 8'(an), 8'(ea));
    chk({tag, " seg"}, 8'(seg), 8'(s));
    chk({tag, " dp"}, 8'(dp), 8'(d));
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, " an"}, 8'(an), 8'h0E);
    chk({tag, " seg"}, 8'(seg), 8'h7F);
    chk({tag, " dp"}, 8'(dp), 8'h01);
    chk({tag, " bad"}, 8'(bad_char), 8'h00);
    chk({tag, " err"}, err_cnt, 8'h00);
  endtask

  initial begin
    tick();
    tick();
    reset_vals("rst");
    reset_n = 1'b1;

    // Idle scan: an steps every 4 edges, first advance after 4 edges.
    tick();
    chk("e1 an", 8'(an), 8'h0E);
    chk("e1 seg", 8'(seg), 8'h7F);
    tick(); tick(); tick();
    chk("e4 an", 8'(an), 8'h0E);
    tick();
    chk("e5 an", 8'(an), 8'h0D);
    chk("e5 dp", 8'(dp), 8'h01);
    repeat (4) tick();
    chk("e9 an", 8'(an), 8'h0B);
    chk("e9 seg", 8'(seg), 8'h7F);
    repeat (4) tick();
    chk("e13 an", 8'(an), 8'h07);
    repeat (4) tick();
    chk("e17 an", 8'(an), 8'h0E);
    chk("e17 seg", 8'(seg), 8'h7F);

    send("1"); send("2"); send("3"); send("4");
    digit("1234 d0", 0, 7'h19, 1'b1);
    digit("1234 d1", 1, 7'h30, 1'b1);
    digit("1234 d2", 2, 7'h24, 1'b1);
    digit("1234 d3", 3, 7'h79, 1'b1);

    send("5"); send("a"); send("."); send("7");
    digit("5a.7 d0", 0, 7'h78, 1'b1);
    digit("5a.7 d1", 1, 7'h08, 1'b0);
    digit("5a.7 d2", 2, 7'h12, 1'b1);
    digit("5a.7 d3", 3, 7'h19, 1'b1);

    send(8'h5A);
    chk("Z bad", 8'(bad_char), 8'h01);
    chk("Z err", err_cnt, 8'h01);
    tick();
    chk("Z bad off", 8'(bad_char), 8'h00);
    send(8'h0D);
    chk("CR bad", 8'(bad_char), 8'h00);
    chk("CR err", err_cnt, 8'h01);
    digit("Z d0", 0, 7'h78, 1'b1);
    digit("Z d1", 1, 7'h08, 1'b0);

    send("F"); send("0"); send("8"); send("9");
    digit("F089 d0", 0, 7'h10, 1'b1);
    digit("F089 d1", 1, 7'h00, 1'b1);
    digit("F089 d2", 2, 7'h40, 1'b1);
    digit("F089 d3", 3, 7'h0E, 1'b1);

    send("b"); send("C"); send("d"); send(8'h0A); send("E"); send("6");
    chk("LF bad", 8'(bad_char), 8'h00);
    digit("bCdE6 d0", 0, 7'h02, 1'b1);
    digit("bCdE6 d1", 1, 7'h06, 1'b1);
    digit("bCdE6 d2", 2, 7'h21, 1'b1);
    digit("bCdE6 d3", 3, 7'h46, 1'b1);
    chk("bCdE6 err", err_cnt, 8'h01);

    // 260 back-to-back bad bytes on top of the earlier one.
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (253) tick();
    chk("storm 254", err_cnt, 8'hFE);
    tick();
    chk("storm 255", err_cnt, 8'hFF);
    repeat (6) tick();
    chk("storm sat", err_cnt, 8'hFF);
    chk("storm bad", 8'(bad_char), 8'h01);
    rx_valid = 1'b0;
    tick();
    chk("storm end", 8'(bad_char), 8'h00);

    send("#");
    send(".");
    digit("clr d0", 0, 7'h7F, 1'b1);
    digit("clr d1", 1, 7'h7F, 1'b1);
    digit("clr d2", 2, 7'h7F, 1'b1);
    digit("clr d3", 3, 7'h7F, 1'b1);
    chk("clr err", err_cnt, 8'hFF);

    // Reset while digits shown, a bad pulse pending and a strobe in flight.
    send("3"); send("8"); send(8'h5A);
    rx_valid = 1'b1;
    rx_data  = "9";
    #2;
    reset_n = 1'b0;
    #1;
    reset_vals("mid");
    rx_valid = 1'b0;
    tick();
    tick();
    reset_vals("mid hold");
    reset_n = 1'b1;
    repeat (4) tick();
    chk("rel e4 an", 8'(an), 8'h0E);
    tick();
    chk("rel e5 an", 8'(an), 8'h0D);
    digit("rel d0", 0, 7'h7F, 1'b1);
    digit("rel d1", 1, 7'h7F, 1'b1);
    digit("rel d2", 2, 7'h7F, 1'b1);
    chk("rel err", err_cnt, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
